rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (wn/d/we) among NREQ writeback requesters
//  (ALU, load unit, multi-cycle mul/div) with round-robin arbitration and a registered output stage.
//  Holds a 31-entry pending-write scoreboard so decode can stall on RAW/WAW hazards.
//  Sits between the execute/memory units and the regfile write port; read-port stall queries come from decode.
// PARAMETERS
//  NREQ   3   number of writeback requesters (2..8)
//  DW     32  data width
// PORTS
//  clk        in   1        clock, rising edge
//  clrn       in   1        reset, asynchronous, active-low
//  req_valid  in   NREQ     requester i has a result to write
//  req_wn     in   5*NREQ   dest reg of requester i, bits [5i+4:5i]
//  req_d      in   DW*NREQ  data of requester i, bits [DW*i+DW-1:DW*i]
//  req_ready  out  NREQ     one-hot grant; handshake done when valid&ready
//  iss_valid  in   1        decode issues instr that will write iss_wn
//  iss_wn     in   5        dest reg of issued instr
//  iss_ready  out  1        issue accepted (0 = WAW stall)
//  rna, rnb   in   5        decode source regs
//  busy_a     out  1        rna has pending write (RAW stall)
//  busy_b     out  1        rnb has pending write
//  wn         out  5        to regfile wn
//  d          out  DW       to regfile d
//  we         out  1        to regfile we
//  fwd_a/b_hit out 1        WB_FWD_EN only: see CONFIGURATION
//  fwd_data   out  DW       WB_FWD_EN only
// BEHAVIOUR
//  - Reset (clrn=0, async): we=0, wn=0, d=0, all scoreboard bits 0, rr pointer=NREQ-1 (req 0 first).
//  - Arbitration, combinational: scan from (ptr+1) mod NREQ upward with wrap; first valid wins.
//    req_ready one-hot or zero; ready never asserted without valid. No valid -> ptr unchanged.
//  - On posedge with grant g: ptr<=g; wn<=req_wn[g]; d<=req_d[g]; we<=(req_wn[g]!=0).
//    No grant: we<=0; wn/d hold. Latency: accept cycle N -> we high cycle N+1 -> regfile written at end of N+1.
//  - Max 1 write/cycle; each requester waits at most NREQ-1 grants while valid (fairness).
//  - Requester must hold valid/wn/d stable until ready; dropping valid before grant is allowed.
//  - Scoreboard sb[1..31]; sb[0] reads 0 always.
//    set: iss_valid & iss_ready & iss_wn!=0 -> sb[iss_wn]<=1 at posedge.
//    clear: we & wn!=0 -> sb[wn]<=0 at posedge (write really performed).
//    Same reg set and clear in same cycle: set wins (new producer).
//  - iss_ready = !(iss_wn!=0 & sb[iss_wn]); iss_wn=0 always ready, no bit set.
//  - busy_a = (rna!=0)&sb[rna]; busy_b likewise; combinational from current sb.
//    Bit is cleared the same edge regfile is written, so busy drops exactly when regfile holds new value.
//  - Writeback to a non-busy reg is legal (written; sb untouched).
//  - clrn mid-operation: in-flight registered write dropped (we=0); all pending bits lost.
// CONFIGURATION
//  WB_FWD_EN defined: fwd_a_hit=we&(wn!=0)&(wn==rna); fwd_b_hit likewise for rnb; fwd_data=d.
//    busy_a/busy_b are masked to 0 when corresponding hit asserted (decode uses forwarded data).
//  WB_FWD_EN undefined: fwd_a_hit=fwd_b_hit=0, fwd_data=0; busy_a/b unmasked.
// TESTING
//  1 Reset: clrn=0 with all reqs valid -> we=0, req_ready=0, busy_a/b=0; release -> req 0 granted first.
//  2 All 3 valid continuously, wn=1/2/3 -> grants 0,1,2,0,... ; we=1 every cycle one cycle after grant.
//  3 Issue wn=5, then rna=5 -> busy_a=1; req1 writes r5 data 0xDEADBEEF -> busy_a drops cycle after we=1, regfile r5=0xDEADBEEF.
//  4 r7 busy, iss_wn=7 -> iss_ready=0; iss_wn=0 -> iss_ready=1, no sb change.
//  5 Same cycle: we writes r9 and issue r9 -> sb[9] stays 1; req with wn=0 granted -> we=0.
//  6 WB_FWD_EN: we=1,wn=4,d=0x55,rna=4 -> fwd_a_hit=1, fwd_data=0x55, busy_a=0; undefined -> fwd_a_hit=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin grant over NREQ requesters, registered write port,
// 31-entry pending-write scoreboard. Optional forwarding of the in-flight write under `WB_FWD_EN.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_wn,
  input  logic [DW*NREQ-1:0] req_d,
  output logic [NREQ-1:0]   req_ready,
  input  logic              iss_valid,
  input  logic [4:0]        iss_wn,
  output logic              iss_ready,
  input  logic [4:0]        rna,
  input  logic [4:0]        rnb,
  output logic              busy_a,
  output logic              busy_b,
  output logic [4:0]        wn,
  output logic [DW-1:0]     d,
  output logic              we,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [DW-1:0]     fwd_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx_p0;
  logic            found_p0;
  logic [4:0]      gwn_p0;
  logic [DW-1:0]   gd_p0;
  logic [31:0]     sb;
  logic [31:0]     sb_nxt;
  logic            iss_set;
  logic            raw_a;
  logic            raw_b;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NREQ;
    return s[PW-1:0];
  endfunction

  // Stage p0: combinational round-robin scan starting just after the last winner
  always_comb begin
    gidx_p0  = '0;
    found_p0 = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found_p0 && req_valid[rr_idx(ptr, k)]) begin
        found_p0 = 1'b1;
        gidx_p0  = rr_idx(ptr, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found_p0 && clrn) req_ready[gidx_p0] = 1'b1;
  end

  assign gwn_p0 = req_wn[int'(gidx_p0)*5 +: 5];
  assign gd_p0  = req_d[int'(gidx_p0)*DW +: DW];

  assign iss_ready = !((iss_wn != 5'd0) && sb[iss_wn]);
  assign iss_set   = iss_valid && iss_ready && (iss_wn != 5'd0);

  // A new producer issued on the same edge the old value lands keeps the bit set
  always_comb begin
    sb_nxt = sb;
    if (we && (wn != 5'd0)) sb_nxt[wn] = 1'b0;
    if (iss_set) sb_nxt[iss_wn] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  // Stage p1: registered write port, rr pointer and scoreboard
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ptr <= PW'(NREQ - 1);
      wn  <= '0;
      d   <= '0;
      we  <= 1'b0;
      sb  <= '0;
    end else begin
      we <= 1'b0;
      if (found_p0) begin
        ptr <= gidx_p0;
        wn  <= gwn_p0;
        d   <= gd_p0;
        we  <= (gwn_p0 != 5'd0);
      end
      sb <= sb_nxt;
    end
  end

  assign raw_a = (rna != 5'd0) && sb[rna];
  assign raw_b = (rnb != 5'd0) && sb[rnb];

`ifdef WB_FWD_EN
  assign fwd_a_hit = we && (wn != 5'd0) && (wn == rna);
  assign fwd_b_hit = we && (wn != 5'd0) && (wn == rnb);
  assign fwd_data  = d;
  assign busy_a    = raw_a && !fwd_a_hit;
  assign busy_b    = raw_b && !fwd_b_hit;
`else
  assign fwd_a_hit = 1'b0;
  assign fwd_b_hit = 1'b0;
  assign fwd_data  = '0;
  assign busy_a    = raw_a;
  assign busy_b    = raw_b;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (NREQ=3, DW=32); inputs change on negedge, outputs sampled 1ns later.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clrn;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_wn;
  logic [DW*NREQ-1:0] req_d;
  logic [NREQ-1:0]   req_ready;
  logic              iss_valid;
  logic [4:0]        iss_wn;
  logic              iss_ready;
  logic [4:0]        rna, rnb;
  logic              busy_a, busy_b;
  logic [4:0]        wn;
  logic [DW-1:0]     d;
  logic              we;
  logic              fwd_a_hit, fwd_b_hit;
  logic [DW-1:0]     fwd_data;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] rf [32];

  rf_wb_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .clrn(clrn), .req_valid(req_valid), .req_wn(req_wn), .req_d(req_d),
    .req_ready(req_ready), .iss_valid(iss_valid), .iss_wn(iss_wn), .iss_ready(iss_ready),
    .rna(rna), .rnb(rnb), .busy_a(busy_a), .busy_b(busy_b), .wn(wn), .d(d), .we(we),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (we) rf[wn] <= d;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; iss_valid = 1'b0; iss_wn = 5'd0; rna = 5'd0; rnb = 5'd0;
    req_valid = 3'b111;
    req_wn = {5'd3, 5'd2, 5'd1};
    req_d  = {32'h33333333, 32'h22222222, 32'h11111111};
    step(); step(); settle();
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", we); end
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++; if ({busy_a, busy_b} !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", {busy_a, busy_b}); end
    checks++; if ({wn, d} !== 37'd0) begin failures++; $display("FAIL reset_wn_d got=%h/%h exp=0/0", wn, d); end
    step(); clrn = 1'b1; settle();
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL reset_first_grant got=%b exp=001", req_ready); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_rdy [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [4:0]  exp_wn  [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    logic [31:0] exp_d   [6] = '{32'h11111111, 32'h22222222, 32'h33333333,
                                 32'h11111111, 32'h22222222, 32'h33333333};
    for (int i = 0; i < 6; i++) begin
      checks++; if (req_ready !== exp_rdy[i]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, exp_rdy[i]); end
      step(); settle();
      checks++; if ({we, wn, d} !== {1'b1, exp_wn[i], exp_d[i]}) begin
        failures++; $display("FAIL rr_write%0d got=we%b wn%0d d%h exp=we1 wn%0d d%h", i, we, wn, d, exp_wn[i], exp_d[i]);
      end
    end
    req_valid = 3'b010; settle();
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL rr_single got=%b exp=010", req_ready); end
    step(); req_valid = 3'b000; settle();
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL rr_none got=%b exp=000", req_ready); end
    step(); settle();
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL rr_idle_we got=%b exp=0", we); end
    req_valid = 3'b111; settle();
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL rr_ptr_hold got=%b exp=100", req_ready); end
    req_valid = 3'b000;
    step(); step();
  endtask

  task automatic test_raw();
    iss_valid = 1'b1; iss_wn = 5'd5; settle();
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL raw_iss_ready got=%b exp=1", iss_ready); end
    step(); iss_valid = 1'b0; rna = 5'd5; rnb = 5'd5; settle();
    checks++; if ({busy_a, busy_b} !== 2'b11) begin failures++; $display("FAIL raw_busy_set got=%b exp=11", {busy_a, busy_b}); end
    req_valid = 3'b010; req_wn = {5'd0, 5'd5, 5'd0}; req_d = {32'h0, 32'hDEADBEEF, 32'h0}; settle();
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL raw_grant got=%b exp=010", req_ready); end
    step(); req_valid = 3'b000; settle();
    checks++; if ({we, wn} !== {1'b1, 5'd5}) begin failures++; $display("FAIL raw_we got=we%b wn%0d exp=we1 wn5", we, wn); end
    checks++; if (busy_a !== !FWD) begin failures++; $display("FAIL raw_busy_during_we got=%b exp=%b", busy_a, !FWD); end
    step(); settle();
    checks++; if ({busy_a, busy_b} !== 2'b00) begin failures++; $display("FAIL raw_busy_clear got=%b exp=00", {busy_a, busy_b}); end
    checks++; if (rf[5] !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_regfile got=%h exp=deadbeef", rf[5]); end
  endtask

  task automatic test_waw();
    iss_valid = 1'b1; iss_wn = 5'd7;
    step(); settle();
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL waw_stall got=%b exp=0", iss_ready); end
    iss_wn = 5'd0; settle();
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL waw_r0_ready got=%b exp=1", iss_ready); end
    step(); iss_valid = 1'b0; rna = 5'd0; rnb = 5'd7; settle();
    checks++; if ({busy_a, busy_b} !== 2'b01) begin failures++; $display("FAIL waw_sb_after_r0 got=%b exp=01", {busy_a, busy_b}); end
    req_valid = 3'b001; req_wn = {5'd0, 5'd0, 5'd7}; req_d = {32'h0, 32'h0, 32'hA5A5A5A5};
    step(); req_valid = 3'b000; step(); settle();
    checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL waw_cleared got=%b exp=0", busy_b); end
  endtask

  task automatic test_same_cycle();
    rna = 5'd9; rnb = 5'd0;
    req_valid = 3'b100; req_wn = {5'd9, 5'd0, 5'd0}; req_d = {32'h99999999, 32'h0, 32'h0};
    step(); req_valid = 3'b000; iss_valid = 1'b1; iss_wn = 5'd9; settle();
    checks++; if ({we, wn, iss_ready} !== {1'b1, 5'd9, 1'b1}) begin
      failures++; $display("FAIL same_setup got=we%b wn%0d rdy%b exp=we1 wn9 rdy1", we, wn, iss_ready);
    end
    step(); iss_valid = 1'b0; settle();
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL same_set_wins got=%b exp=1", busy_a); end
    req_valid = 3'b001; req_wn = {5'd0, 5'd0, 5'd0}; req_d = {32'h0, 32'h0, 32'h12345678}; settle();
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL same_r0_grant got=%b exp=001", req_ready); end
    step(); req_valid = 3'b000; settle();
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL same_r0_we got=%b exp=0", we); end
  endtask

  task automatic test_fwd();
    iss_valid = 1'b1; iss_wn = 5'd4;
    step(); iss_valid = 1'b0; rna = 5'd4; rnb = 5'd6;
    req_valid = 3'b001; req_wn = {5'd0, 5'd0, 5'd4}; req_d = {32'h0, 32'h0, 32'h00000055};
    step(); req_valid = 3'b000; settle();
    checks++; if (fwd_a_hit !== FWD) begin failures++; $display("FAIL fwd_a_hit got=%b exp=%b", fwd_a_hit, FWD); end
    checks++; if (fwd_b_hit !== 1'b0) begin failures++; $display("FAIL fwd_b_hit got=%b exp=0", fwd_b_hit); end
    checks++; if (fwd_data !== (FWD ? 32'h55 : 32'h0)) begin failures++; $display("FAIL fwd_data got=%h exp=%h", fwd_data, FWD ? 32'h55 : 32'h0); end
    checks++; if (busy_a !== !FWD) begin failures++; $display("FAIL fwd_busy_mask got=%b exp=%b", busy_a, !FWD); end
    step();
  endtask

  task automatic test_reset_mid();
    iss_valid = 1'b1; iss_wn = 5'd3; rna = 5'd3;
    step(); iss_valid = 1'b0;
    req_valid = 3'b010; req_wn = {5'd0, 5'd8, 5'd0}; req_d = {32'h0, 32'h88888888, 32'h0};
    step(); req_valid = 3'b000; settle();
    checks++; if ({we, busy_a} !== 2'b11) begin failures++; $display("FAIL mid_pre got=%b exp=11", {we, busy_a}); end
    #2 clrn = 1'b0; #1;
    checks++; if ({we, busy_a} !== 2'b00) begin failures++; $display("FAIL mid_reset got=%b exp=00", {we, busy_a}); end
    step(); clrn = 1'b1; step(); settle();
    checks++; if (rf[8] === 32'h88888888) begin failures++; $display("FAIL mid_dropped got=%h exp=not 88888888", rf[8]); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    test_reset();
    test_round_robin();
    test_raw();
    test_waw();
    test_same_cycle();
    test_fwd();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
